// File: rtl/sp_pkg.sv
// Shared definitions for the single-precision divider: FSM states,
// IEEE-754 single constants and the unbiased exponent limits.
package sp_pkg;

    typedef enum logic [4:0] {
        st_get_a,
        st_get_b,
        st_unpack,
        st_special_cases,
        st_normalise_a,
        st_normalise_b,
        st_divide_0,
        st_divide_1,
        st_divide_2,
        st_divide_3,
        st_normalise_1,
        st_normalise_2,
        st_round,
        st_pack,
        st_put_z
    } state_t;

    localparam int EXP_BIAS = 127;

    localparam logic [31:0] QNAN    = 32'hFFC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    // Unbiased exponent limits as seen after unpacking into 10-bit signed.
    localparam logic signed [9:0] EXP_MIN_NORM = -10'sd126;
    localparam logic signed [9:0] EXP_DENORM   = -10'sd127;
    localparam logic signed [9:0] EXP_SPECIAL  = 10'sd128;
    localparam logic signed [9:0] EXP_MAX_NORM = 10'sd127;

    // Restoring-division iterations, each spending one divide_1 and one divide_2 cycle.
    localparam int DIV_STEPS = 50;

endpackage

// File: rtl/sp_div.sv
// IEEE-754 single-precision divider z = a / b using iterative restoring
// division, round-to-nearest-even and full denormal support.
// Handshakes: a transfer happens on a rising clk edge where both stb and ack
// are high; ack/stb are registered, and a producer must hold its data stable
// while its stb is high.
module sp_div
    import sp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    state_t state_q, state_d;
    logic a_ack_q, a_ack_d, b_ack_q, b_ack_d, z_stb_q, z_stb_d;
    logic [31:0] z_out_q, z_out_d;

    logic [31:0] a_q, a_d, b_q, b_d, z_q, z_d;
    logic [23:0] a_m_q, a_m_d, b_m_q, b_m_d, z_m_q, z_m_d;
    logic signed [9:0] a_e_q, a_e_d, b_e_q, b_e_d, z_e_q, z_e_d;
    logic a_s_q, a_s_d, b_s_q, b_s_d, z_s_q, z_s_d;
    logic guard_q, guard_d, round_bit_q, round_bit_d, sticky_q, sticky_d;
    logic [26:0] quotient_q, quotient_d;
    logic [50:0] dividend_q, dividend_d, remainder_q, remainder_d;
    logic [5:0]  count_q, count_d;

    logic z_sign;
    logic a_zero, b_zero;

    assign z_sign = a_s_q ^ b_s_q;
    assign a_zero = (a_e_q == EXP_DENORM) && (a_m_q == 24'd0);
    assign b_zero = (b_e_q == EXP_DENORM) && (b_m_q == 24'd0);

    assign input_a_ack  = a_ack_q;
    assign input_b_ack  = b_ack_q;
    assign output_z     = z_out_q;
    assign output_z_stb = z_stb_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= st_get_a;
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            z_stb_q <= 1'b0;
            z_out_q <= 32'd0;
        end else begin
            state_q <= state_d;
            a_ack_q <= a_ack_d;
            b_ack_q <= b_ack_d;
            z_stb_q <= z_stb_d;
            z_out_q <= z_out_d;
        end
    end

    // Datapath registers carry no reset; every state that reads them writes them first.
    always_ff @(posedge clk) begin
        a_q         <= a_d;
        b_q         <= b_d;
        z_q         <= z_d;
        a_m_q       <= a_m_d;
        b_m_q       <= b_m_d;
        z_m_q       <= z_m_d;
        a_e_q       <= a_e_d;
        b_e_q       <= b_e_d;
        z_e_q       <= z_e_d;
        a_s_q       <= a_s_d;
        b_s_q       <= b_s_d;
        z_s_q       <= z_s_d;
        guard_q     <= guard_d;
        round_bit_q <= round_bit_d;
        sticky_q    <= sticky_d;
        quotient_q  <= quotient_d;
        dividend_q  <= dividend_d;
        remainder_q <= remainder_d;
        count_q     <= count_d;
    end

    always_comb begin
        state_d     = state_q;
        a_ack_d     = a_ack_q;
        b_ack_d     = b_ack_q;
        z_stb_d     = z_stb_q;
        z_out_d     = z_out_q;
        a_d         = a_q;
        b_d         = b_q;
        z_d         = z_q;
        a_m_d       = a_m_q;
        b_m_d       = b_m_q;
        z_m_d       = z_m_q;
        a_e_d       = a_e_q;
        b_e_d       = b_e_q;
        z_e_d       = z_e_q;
        a_s_d       = a_s_q;
        b_s_d       = b_s_q;
        z_s_d       = z_s_q;
        guard_d     = guard_q;
        round_bit_d = round_bit_q;
        sticky_d    = sticky_q;
        quotient_d  = quotient_q;
        dividend_d  = dividend_q;
        remainder_d = remainder_q;
        count_d     = count_q;

        unique case (state_q)
            st_get_a: begin
                a_ack_d = 1'b1;
                if (a_ack_q && input_a_stb) begin
                    a_d     = input_a;
                    a_ack_d = 1'b0;
                    state_d = st_get_b;
                end
            end
            st_get_b: begin
                b_ack_d = 1'b1;
                if (b_ack_q && input_b_stb) begin
                    b_d     = input_b;
                    b_ack_d = 1'b0;
                    state_d = st_unpack;
                end
            end
            st_unpack: begin
                a_m_d   = {1'b0, a_q[22:0]};
                b_m_d   = {1'b0, b_q[22:0]};
                a_e_d   = {2'b00, a_q[30:23]} - 10'(EXP_BIAS);
                b_e_d   = {2'b00, b_q[30:23]} - 10'(EXP_BIAS);
                a_s_d   = a_q[31];
                b_s_d   = b_q[31];
                state_d = st_special_cases;
            end
            st_special_cases: begin
                state_d = st_put_z;
                if ((a_e_q == EXP_SPECIAL && a_m_q != 24'd0) ||
                    (b_e_q == EXP_SPECIAL && b_m_q != 24'd0)) begin
                    z_d = QNAN;
                end else if (a_e_q == EXP_SPECIAL) begin
                    z_d = (b_e_q == EXP_SPECIAL) ? QNAN : (POS_INF | {z_sign, 31'd0});
                end else if (b_e_q == EXP_SPECIAL) begin
                    z_d = {z_sign, 31'd0};
                end else if (a_zero) begin
                    z_d = b_zero ? QNAN : {z_sign, 31'd0};
                end else if (b_zero) begin
                    z_d = POS_INF | {z_sign, 31'd0};
                end else begin
                    state_d = st_normalise_a;
                    if (a_e_q == EXP_DENORM) a_e_d = EXP_MIN_NORM;
                    else                     a_m_d[23] = 1'b1;
                    if (b_e_q == EXP_DENORM) b_e_d = EXP_MIN_NORM;
                    else                     b_m_d[23] = 1'b1;
                end
            end
            st_normalise_a: begin
                if (!a_m_q[23]) begin
                    a_m_d = {a_m_q[22:0], 1'b0};
                    a_e_d = a_e_q - 10'sd1;
                end else begin
                    state_d = st_normalise_b;
                end
            end
            st_normalise_b: begin
                if (!b_m_q[23]) begin
                    b_m_d = {b_m_q[22:0], 1'b0};
                    b_e_d = b_e_q - 10'sd1;
                end else begin
                    state_d = st_divide_0;
                end
            end
            st_divide_0: begin
                z_s_d       = z_sign;
                z_e_d       = a_e_q - b_e_q;
                dividend_d  = {a_m_q, 27'd0};
                quotient_d  = 27'd0;
                remainder_d = 51'd0;
                count_d     = 6'd0;
                state_d     = st_divide_1;
            end
            st_divide_1: begin
                quotient_d  = {quotient_q[25:0], 1'b0};
                remainder_d = {remainder_q[49:0], dividend_q[50]};
                dividend_d  = {dividend_q[49:0], 1'b0};
                state_d     = st_divide_2;
            end
            st_divide_2: begin
                if (remainder_q >= {27'd0, b_m_q}) begin
                    quotient_d[0] = 1'b1;
                    remainder_d   = remainder_q - {27'd0, b_m_q};
                end
                count_d = count_q + 6'd1;
                state_d = (count_q == 6'(DIV_STEPS - 1)) ? st_divide_3 : st_divide_1;
            end
            st_divide_3: begin
                z_m_d       = quotient_q[26:3];
                guard_d     = quotient_q[2];
                round_bit_d = quotient_q[1];
                sticky_d    = quotient_q[0] | (remainder_q != 51'd0);
                state_d     = st_normalise_1;
            end
            st_normalise_1: begin
                // The round bit moves up into guard; its old slot is already covered by sticky.
                if (!z_m_q[23]) begin
                    z_e_d       = z_e_q - 10'sd1;
                    z_m_d       = {z_m_q[22:0], guard_q};
                    guard_d     = round_bit_q;
                    round_bit_d = 1'b0;
                end else begin
                    state_d = st_normalise_2;
                end
            end
            st_normalise_2: begin
                if (z_e_q < EXP_MIN_NORM) begin
                    z_e_d       = z_e_q + 10'sd1;
                    z_m_d       = {1'b0, z_m_q[23:1]};
                    guard_d     = z_m_q[0];
                    round_bit_d = guard_q;
                    sticky_d    = sticky_q | round_bit_q;
                end else begin
                    state_d = st_round;
                end
            end
            st_round: begin
                if (guard_q && (round_bit_q || sticky_q || z_m_q[0])) begin
                    z_m_d = z_m_q + 24'd1;
                    if (z_m_q == 24'hFFFFFF) z_e_d = z_e_q + 10'sd1;
                end
                state_d = st_pack;
            end
            st_pack: begin
                z_d = {z_s_q, z_e_q[7:0] + 8'(EXP_BIAS), z_m_q[22:0]};
                if (z_e_q == EXP_MIN_NORM && !z_m_q[23]) z_d[30:23] = 8'd0;
                if (z_e_q > EXP_MAX_NORM) z_d = POS_INF | {z_s_q, 31'd0};
                state_d = st_put_z;
            end
            st_put_z: begin
                z_stb_d = 1'b1;
                z_out_d = z_q;
                if (z_stb_q && output_z_ack) begin
                    z_stb_d = 1'b0;
                    state_d = st_get_a;
                end
            end
            default: state_d = st_get_a;
        endcase
    end

endmodule

// File: tb/tb_sp_div.sv
// Directed bench for sp_div: hand-computed quotients, special values,
// denormal/underflow rounding, handshake timing and mid-operation reset.
module tb_sp_div;
    import sp_pkg::*;

    localparam int WAIT_LIM = 600;

    logic        clk;
    logic        rst;
    logic [31:0] input_a, input_b, output_z;
    logic        input_a_stb, input_a_ack;
    logic        input_b_stb, input_b_ack;
    logic        output_z_stb, output_z_ack;

    logic [31:0] exp_q[$];
    int          total;
    int          bad;
    bit          ack_tied;

    sp_div dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .input_b      (input_b),
        .input_b_stb  (input_b_stb),
        .input_b_ack  (input_b_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Driver tasks; all activity happens #1 after a rising edge.
    task automatic send_a(input logic [31:0] a);
        int cyc = 0;
        input_a     = a;
        input_a_stb = 1'b1;
        while (!input_a_ack && cyc < WAIT_LIM) begin
            @(posedge clk); #1; cyc++;
        end
        if (!input_a_ack) chk("a_ack_timeout", {31'd0, input_a_ack}, 32'd1);
        @(posedge clk); #1;
        input_a_stb = 1'b0;
    endtask

    task automatic send_b(input logic [31:0] b, input int delay);
        int cyc = 0;
        input_b = b;
        for (int i = 0; i < delay; i++) begin
            @(posedge clk); #1;
            chk("b_ack_wait", {31'd0, input_b_ack}, 32'd1);
        end
        input_b_stb = 1'b1;
        while (!input_b_ack && cyc < WAIT_LIM) begin
            @(posedge clk); #1; cyc++;
        end
        if (!input_b_ack) chk("b_ack_timeout", {31'd0, input_b_ack}, 32'd1);
        @(posedge clk); #1;
        input_b_stb = 1'b0;
    endtask

    // Scoreboard side: wait for a result, compare against the expected queue.
    task automatic get_z(input string tag, input int hold, input int lat);
        int          cyc = 0;
        logic [31:0] want;
        while (!output_z_stb && cyc < WAIT_LIM) begin
            @(posedge clk); #1; cyc++;
        end
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        chk({tag, "_stb"}, {31'd0, output_z_stb}, 32'd1);
        if (lat >= 0) chk({tag, "_lat"}, cyc, lat);
        chk(tag, output_z, want);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_stb"}, {31'd0, output_z_stb}, 32'd1);
            chk({tag, "_hold_z"}, output_z, want);
        end
        output_z_ack = 1'b1;
        @(posedge clk); #1;
        if (!ack_tied) output_z_ack = 1'b0;
        chk({tag, "_stb_drop"}, {31'd0, output_z_stb}, 32'd0);
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] want, input int bdelay, input int hold,
                         input int lat);
        exp_q.push_back(want);
        send_a(a);
        send_b(b, bdelay);
        get_z(tag, hold, lat);
    endtask

    // Reset and test sequence
    initial begin
        int cyc;
        total        = 0;
        bad          = 0;
        ack_tied     = 1'b0;
        rst          = 1'b0;
        input_a      = 32'd0;
        input_b      = 32'd0;
        input_a_stb  = 1'b0;
        input_b_stb  = 1'b0;
        output_z_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_ack", {31'd0, input_a_ack}, 32'd0);
        chk("rst_b_ack", {31'd0, input_b_ack}, 32'd0);
        chk("rst_z_stb", {31'd0, output_z_stb}, 32'd0);
        chk("rst_z", output_z, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        do_op("six_div_two",   32'h40C00000, 32'h40000000, 32'h40400000, 0, 0, 111);
        do_op("one_div_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 0, 0, 112);
        do_op("two_div_three", 32'h40000000, 32'h40400000, 32'h3F2AAAAB, 0, 0, -1);
        do_op("one_div_seven", 32'h3F800000, 32'h40E00000, 32'h3E124925, 0, 0, -1);
        do_op("neg_six_two",   32'hC0C00000, 32'h40000000, 32'hC0400000, 0, 0, -1);
        do_op("max_div_max",   32'h7F7FFFFF, 32'h7F7FFFFF, 32'h3F800000, 0, 0, -1);
        do_op("one_div_zero",  32'h3F800000, 32'h00000000, 32'h7F800000, 0, 0, -1);
        do_op("neg_div_zero",  32'hC0400000, 32'h00000000, 32'hFF800000, 0, 0, -1);
        do_op("zero_div_zero", 32'h00000000, 32'h00000000, 32'hFFC00000, 0, 0, -1);
        do_op("inf_div_ninf",  32'h7F800000, 32'hFF800000, 32'hFFC00000, 0, 0, -1);
        do_op("nan_div_one",   32'h7FC00000, 32'h3F800000, 32'hFFC00000, 0, 0, -1);
        do_op("one_div_nan",   32'h3F800000, 32'h7FC00000, 32'hFFC00000, 0, 0, -1);
        do_op("inf_div_two",   32'h7F800000, 32'h40000000, 32'h7F800000, 0, 0, -1);
        do_op("ninf_div_two",  32'hFF800000, 32'h40000000, 32'hFF800000, 0, 0, -1);
        do_op("one_div_inf",   32'h3F800000, 32'h7F800000, 32'h00000000, 0, 0, -1);
        do_op("neg_div_inf",   32'hBF800000, 32'h7F800000, 32'h80000000, 0, 0, -1);
        do_op("zero_div_five", 32'h00000000, 32'h40A00000, 32'h00000000, 0, 0, -1);
        do_op("nzero_div_5",   32'h80000000, 32'h40A00000, 32'h80000000, 0, 0, -1);
        do_op("min_norm_div2", 32'h00800000, 32'h40000000, 32'h00400000, 0, 0, -1);
        do_op("overflow",      32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 0, 0, -1);
        do_op("one_div_tiny",  32'h3F800000, 32'h00000001, 32'h7F800000, 0, 0, -1);
        do_op("tiny_div_one",  32'h00000001, 32'h3F800000, 32'h00000001, 0, 0, -1);
        do_op("denorm_tie_up", 32'h00000003, 32'h40000000, 32'h00000002, 0, 0, -1);
        do_op("denorm_tie_dn", 32'h00000001, 32'h40000000, 32'h00000000, 0, 0, -1);
        do_op("denorm_denorm", 32'h00000002, 32'h00000001, 32'h40000000, 0, 0, -1);

        // Slow consumer and late divisor
        do_op("held_result",   32'h41000000, 32'h40800000, 32'h40000000, 10, 20, -1);

        // Back-to-back with the consumer always ready
        ack_tied     = 1'b1;
        output_z_ack = 1'b1;
        do_op("b2b_0", 32'h40C00000, 32'h40000000, 32'h40400000, 0, 0, 111);
        do_op("b2b_1", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 0, 0, 112);
        do_op("b2b_2", 32'hBF800000, 32'h40000000, 32'hBF000000, 0, 0, -1);
        ack_tied     = 1'b0;
        output_z_ack = 1'b0;

        // Reset while dividing aborts the transaction
        send_a(32'h40C00000);
        send_b(32'h40000000, 0);
        cyc = 0;
        while (dut.state_q != st_divide_2 && cyc < WAIT_LIM) begin
            @(posedge clk); #1; cyc++;
        end
        chk("reach_divide_2", {27'd0, dut.state_q}, {27'd0, st_divide_2});
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_a_ack", {31'd0, input_a_ack}, 32'd0);
        chk("mid_rst_b_ack", {31'd0, input_b_ack}, 32'd0);
        chk("mid_rst_z_stb", {31'd0, output_z_stb}, 32'd0);
        chk("mid_rst_z", output_z, 32'd0);
        chk("mid_rst_state", {27'd0, dut.state_q}, {27'd0, st_get_a});
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 130; i++) begin
            @(posedge clk); #1;
            if (output_z_stb) chk("aborted_no_output", {31'd0, output_z_stb}, 32'd0);
        end
        do_op("after_rst", 32'hBF800000, 32'h40000000, 32'hBF000000, 0, 0, -1);

        chk("exp_q_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
